// File: rtl/dest_pipe_tracker_pkg.sv
// Shared definitions for the E/M/W destination-record tracker:
// record layout, bubble constant and the saturating Tnew decrement.
package dest_pipe_tracker_pkg;

    localparam int TNEW_W = 2;

    typedef struct packed {
        logic [4:0]        a3;
        logic              reg_write;
        logic [TNEW_W-1:0] tnew;
        logic              jal;
        logic              jalr;
    } dest_rec_t;

    localparam dest_rec_t RECORD_BUBBLE = '0;

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
        logic [TNEW_W-1:0] r;
        if (x == {TNEW_W{1'b0}}) begin
            r = {TNEW_W{1'b0}};
        end else begin
            r = x - {{(TNEW_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/dest_pipe_tracker_hazard_stall_cmp.sv
// One source operand's load-use check against the E and M records;
// instantiated once for rs and once for rt.
module hazard_stall_cmp
    import dest_pipe_tracker_pkg::*;
(
    input  logic [4:0]        addr,
    input  logic              use_reg,
    input  logic [TNEW_W-1:0] tuse,
    input  dest_rec_t         rec_e,
    input  dest_rec_t         rec_m,
    output logic              stall
);

    logic hit_e;
    logic hit_m;

    // Stall while a producer in E or M still needs more cycles than the consumer can wait.
    always_comb begin
        hit_e = (addr == rec_e.a3) && rec_e.reg_write && (rec_e.tnew > tuse);
        hit_m = (addr == rec_m.a3) && rec_m.reg_write && (rec_m.tnew > tuse);
        if (use_reg && (addr != 5'd0)) begin
            stall = hit_e || hit_m;
        end else begin
            stall = 1'b0;
        end
    end

endmodule

// File: rtl/dest_pipe_tracker.sv
// Destination-record pipeline for E/M/W feeding the forwarding unit,
// plus the Tuse/Tnew load-use stall and a saturating stall counter.
module dest_pipe_tracker #(
    parameter int STALL_CNT_W = 32,
    parameter int TNEW_W      = dest_pipe_tracker_pkg::TNEW_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             A1_D,
    input  logic [4:0]             A2_D,
    input  logic                   use_rs_D,
    input  logic                   use_rt_D,
    input  logic [TNEW_W-1:0]      Tuse_rs_D,
    input  logic [TNEW_W-1:0]      Tuse_rt_D,
    input  logic [4:0]             A3_D,
    input  logic                   RegWrite_D,
    input  logic [TNEW_W-1:0]      Tnew_D,
    input  logic                   jal_D,
    input  logic                   jalr_D,
    output logic [4:0]             A3_E,
    output logic [4:0]             A3_M,
    output logic [4:0]             A3_W,
    output logic                   RegWrite_E,
    output logic                   RegWrite_M,
    output logic                   RegWrite_W,
    output logic [TNEW_W-1:0]      Tnew_E,
    output logic [TNEW_W-1:0]      Tnew_M,
    output logic [TNEW_W-1:0]      Tnew_W,
    output logic                   jal_E,
    output logic                   jal_M,
    output logic                   jal_W,
    output logic                   jalr_E,
    output logic                   jalr_M,
    output logic                   jalr_W,
    output logic                   stall,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    dest_pipe_tracker_pkg::dest_rec_t rec_e;
    dest_pipe_tracker_pkg::dest_rec_t rec_m;
    dest_pipe_tracker_pkg::dest_rec_t rec_w;
    dest_pipe_tracker_pkg::dest_rec_t rec_d;
    logic stall_rs;
    logic stall_rt;

    hazard_stall_cmp u_cmp_rs (
        .addr    (A1_D),
        .use_reg (use_rs_D),
        .tuse    (Tuse_rs_D),
        .rec_e   (rec_e),
        .rec_m   (rec_m),
        .stall   (stall_rs)
    );

    hazard_stall_cmp u_cmp_rt (
        .addr    (A2_D),
        .use_reg (use_rt_D),
        .tuse    (Tuse_rt_D),
        .rec_e   (rec_e),
        .rec_m   (rec_m),
        .stall   (stall_rt)
    );

    assign stall = stall_rs | stall_rt;

    // Non-writing instructions and writes to $0 become an all-zero record so they never match.
    always_comb begin
        if (RegWrite_D && (A3_D != 5'd0)) begin
            rec_d.a3        = A3_D;
            rec_d.reg_write = 1'b1;
            rec_d.tnew      = Tnew_D;
            rec_d.jal       = jal_D;
            rec_d.jalr      = jalr_D;
        end else begin
            rec_d = dest_pipe_tracker_pkg::RECORD_BUBBLE;
        end
    end

    // Advance records each cycle; E takes a bubble while stalled. Counter saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rec_e     <= dest_pipe_tracker_pkg::RECORD_BUBBLE;
            rec_m     <= dest_pipe_tracker_pkg::RECORD_BUBBLE;
            rec_w     <= dest_pipe_tracker_pkg::RECORD_BUBBLE;
            stall_cnt <= {STALL_CNT_W{1'b0}};
        end else begin
            rec_e      <= stall ? dest_pipe_tracker_pkg::RECORD_BUBBLE : rec_d;
            rec_m      <= rec_e;
            rec_m.tnew <= dest_pipe_tracker_pkg::sat_dec(rec_e.tnew);
            rec_w      <= rec_m;
            rec_w.tnew <= dest_pipe_tracker_pkg::sat_dec(rec_m.tnew);
            if (stall && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt <= stall_cnt;
            end
        end
    end

    assign A3_E       = rec_e.a3;
    assign A3_M       = rec_m.a3;
    assign A3_W       = rec_w.a3;
    assign RegWrite_E = rec_e.reg_write;
    assign RegWrite_M = rec_m.reg_write;
    assign RegWrite_W = rec_w.reg_write;
    assign Tnew_E     = rec_e.tnew;
    assign Tnew_M     = rec_m.tnew;
    assign Tnew_W     = rec_w.tnew;
    assign jal_E      = rec_e.jal;
    assign jal_M      = rec_m.jal;
    assign jal_W      = rec_w.jal;
    assign jalr_E     = rec_e.jalr;
    assign jalr_M     = rec_m.jalr;
    assign jalr_W     = rec_w.jalr;

endmodule

// File: tb/tb_dest_pipe_tracker.sv
// Self-checking bench: a history-based model of the pipeline checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_dest_pipe_tracker;

    localparam int SCW     = 4;
    localparam int CNT_MAX = (1 << SCW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [4:0] A1_D, A2_D, A3_D;
    logic use_rs_D, use_rt_D, RegWrite_D, jal_D, jalr_D;
    logic [1:0] Tuse_rs_D, Tuse_rt_D, Tnew_D;
    logic [4:0] A3_E, A3_M, A3_W;
    logic RegWrite_E, RegWrite_M, RegWrite_W;
    logic [1:0] Tnew_E, Tnew_M, Tnew_W;
    logic jal_E, jal_M, jal_W, jalr_E, jalr_M, jalr_W;
    logic stall;
    logic [SCW-1:0] stall_cnt;

    dest_pipe_tracker #(.STALL_CNT_W(SCW), .TNEW_W(2)) dut (
        .clk(clk), .reset(reset),
        .A1_D(A1_D), .A2_D(A2_D), .use_rs_D(use_rs_D), .use_rt_D(use_rt_D),
        .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D),
        .A3_D(A3_D), .RegWrite_D(RegWrite_D), .Tnew_D(Tnew_D),
        .jal_D(jal_D), .jalr_D(jalr_D),
        .A3_E(A3_E), .A3_M(A3_M), .A3_W(A3_W),
        .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .Tnew_E(Tnew_E), .Tnew_M(Tnew_M), .Tnew_W(Tnew_W),
        .jal_E(jal_E), .jal_M(jal_M), .jal_W(jal_W),
        .jalr_E(jalr_E), .jalr_M(jalr_M), .jalr_W(jalr_W),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: history of what entered E on the last three edges (index = age).
    // Each entry keeps its Tnew at entry; the current Tnew is that minus its age, floored at 0.
    int m_a3[3], m_rw[3], m_tn[3], m_jal[3], m_jalr[3];
    int m_cnt;

    function automatic int m_tnew(input int k);
        return (m_tn[k] - k > 0) ? (m_tn[k] - k) : 0;
    endfunction

    function automatic bit m_hz(input int a, input int u, input int tuse);
        if (u == 0 || a == 0) return 1'b0;
        for (int k = 0; k < 2; k++)
            if (m_rw[k] != 0 && m_a3[k] == a && m_tnew(k) > tuse) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_stall();
        return m_hz(int'(A1_D), int'(use_rs_D), int'(Tuse_rs_D)) ||
               m_hz(int'(A2_D), int'(use_rt_D), int'(Tuse_rt_D));
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                m_a3[k] <= 0; m_rw[k] <= 0; m_tn[k] <= 0; m_jal[k] <= 0; m_jalr[k] <= 0;
            end
            m_cnt <= 0;
        end else begin
            for (int k = 1; k < 3; k++) begin
                m_a3[k] <= m_a3[k-1]; m_rw[k] <= m_rw[k-1]; m_tn[k] <= m_tn[k-1];
                m_jal[k] <= m_jal[k-1]; m_jalr[k] <= m_jalr[k-1];
            end
            if (m_stall() || RegWrite_D == 1'b0 || A3_D == 5'd0) begin
                m_a3[0] <= 0; m_rw[0] <= 0; m_tn[0] <= 0; m_jal[0] <= 0; m_jalr[0] <= 0;
            end else begin
                m_a3[0] <= int'(A3_D); m_rw[0] <= 1; m_tn[0] <= int'(Tnew_D);
                m_jal[0] <= int'(jal_D); m_jalr[0] <= int'(jalr_D);
            end
            if (m_stall()) m_cnt <= (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("stall", int'(stall), int'(m_stall()));
        chk("stall_cnt", int'(stall_cnt), m_cnt);
        chk("A3_E", int'(A3_E), m_a3[0]);
        chk("A3_M", int'(A3_M), m_a3[1]);
        chk("A3_W", int'(A3_W), m_a3[2]);
        chk("RegWrite_E", int'(RegWrite_E), m_rw[0]);
        chk("RegWrite_M", int'(RegWrite_M), m_rw[1]);
        chk("RegWrite_W", int'(RegWrite_W), m_rw[2]);
        chk("Tnew_E", int'(Tnew_E), m_tnew(0));
        chk("Tnew_M", int'(Tnew_M), m_tnew(1));
        chk("Tnew_W", int'(Tnew_W), m_tnew(2));
        chk("jal_E", int'(jal_E), m_jal[0]);
        chk("jal_M", int'(jal_M), m_jal[1]);
        chk("jal_W", int'(jal_W), m_jal[2]);
        chk("jalr_E", int'(jalr_E), m_jalr[0]);
        chk("jalr_M", int'(jalr_M), m_jalr[1]);
        chk("jalr_W", int'(jalr_W), m_jalr[2]);
    end

    task automatic set_d(input int a3, input int rw, input int tn, input int jl, input int jlr,
                         input int a1, input int ur, input int tr,
                         input int a2, input int ut, input int tt);
        A3_D = 5'(a3); RegWrite_D = 1'(rw); Tnew_D = 2'(tn); jal_D = 1'(jl); jalr_D = 1'(jlr);
        A1_D = 5'(a1); use_rs_D = 1'(ur); Tuse_rs_D = 2'(tr);
        A2_D = 5'(a2); use_rt_D = 1'(ut); Tuse_rt_D = 2'(tt);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();

        // Reset asserted between edges mid-stream
        set_d(5, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk("pre_reset_A3_M", int'(A3_M), 5);
        chk("pre_reset_Tnew_M", int'(Tnew_M), 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_A3_E", int'(A3_E), 0);
        chk("rst_A3_M", int'(A3_M), 0);
        chk("rst_RegWrite_E", int'(RegWrite_E), 0);
        chk("rst_Tnew_E", int'(Tnew_E), 0);
        chk("rst_stall", int'(stall), 0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;

        // Load-use: lw $8 (Tnew 2) then a reader with Tuse 1
        set_d(8, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set_d(10, 1, 1, 0, 0, 8, 1, 1, 0, 0, 0);
        #1 chk("lu_stall", int'(stall), 1);
        tick();
        chk("lu_A3_E_bubble", int'(A3_E), 0);
        chk("lu_A3_M", int'(A3_M), 8);
        chk("lu_Tnew_M", int'(Tnew_M), 1);
        chk("lu_stall_drop", int'(stall), 0);
        chk("lu_cnt", int'(stall_cnt), 1);
        tick();
        chk("lu_reader_A3_E", int'(A3_E), 10);
        chk("lu_reader_Tnew_E", int'(Tnew_E), 1);
        chk("lu_A3_W", int'(A3_W), 8);
        chk("lu_Tnew_W", int'(Tnew_W), 0);

        // Branch after load: Tuse 0 on both operands, single stall per cycle
        do_reset();
        set_d(9, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set_d(0, 0, 0, 0, 0, 9, 1, 0, 9, 1, 0);
        #1 chk("br_stall1", int'(stall), 1);
        tick();
        chk("br_stall2", int'(stall), 1);
        chk("br_cnt1", int'(stall_cnt), 1);
        tick();
        chk("br_stall_off", int'(stall), 0);
        chk("br_cnt2", int'(stall_cnt), 2);
        tick();

        // jal / jalr propagation through E, M, W
        do_reset();
        set_d(31, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set_d(7, 1, 1, 0, 1, 31, 1, 0, 31, 1, 0);
        chk("jal_E_lit", int'(jal_E), 1);
        chk("jal_A3_E_lit", int'(A3_E), 31);
        #1 chk("jal_no_stall", int'(stall), 0);
        tick();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("jal_M_lit", int'(jal_M), 1);
        chk("jalr_E_lit", int'(jalr_E), 1);
        tick();
        chk("jal_W_lit", int'(jal_W), 1);
        chk("jal_A3_W_lit", int'(A3_W), 31);
        chk("jal_Tnew_W_lit", int'(Tnew_W), 0);
        chk("jalr_M_lit", int'(jalr_M), 1);
        tick();

        // Normalisation: write to $0, and a non-writing instruction
        do_reset();
        set_d(0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set_d(7, 0, 2, 0, 1, 0, 1, 0, 0, 1, 0);
        chk("norm_A3_E", int'(A3_E), 0);
        chk("norm_RegWrite_E", int'(RegWrite_E), 0);
        chk("norm_Tnew_E", int'(Tnew_E), 0);
        chk("norm_jal_E", int'(jal_E), 0);
        #1 chk("norm_stall", int'(stall), 0);
        tick();
        set_d(0, 0, 0, 0, 0, 7, 1, 0, 7, 1, 0);
        chk("norm2_A3_E", int'(A3_E), 0);
        chk("norm2_jalr_E", int'(jalr_E), 0);
        #1 chk("norm2_stall", int'(stall), 0);
        tick();

        // Saturation: repeated load-use pairs, two stall cycles each
        do_reset();
        for (int i = 0; i < 12; i++) begin
            set_d(12, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
            set_d(0, 0, 0, 0, 0, 0, 0, 0, 12, 1, 0);
            tick(); tick();
        end
        chk("sat_cnt", int'(stall_cnt), CNT_MAX);
        set_d(12, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 12, 1, 0);
        #1 chk("sat_stall", int'(stall), 1);
        tick(); tick();
        chk("sat_hold", int'(stall_cnt), CNT_MAX);
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
